// File: rtl/gowin_pcie_pkg.sv
// Shared types and helpers for the Gowin PCIe glue blocks.
package gowin_pcie_pkg;

  typedef enum logic [1:0] {
    MSI_IDLE,
    MSI_REQ,
    MSI_HOLDOFF
  } msi_state_t;

  localparam int MSINUM_W = 5;

  // eff is always a power of two, so the fold reduces to a mask.
  function automatic int unsigned fold_vec(input int unsigned src, input int unsigned eff);
    return src & (eff - 32'd1);
  endfunction

endpackage

// File: rtl/gowin_msi_arbiter_if.sv
// MSI request/acknowledge handshake between the arbiter and the PCIe hard IP.
interface gowin_msi_arbiter_if;

  logic                                tl_int_req;
  logic [gowin_pcie_pkg::MSINUM_W-1:0] tl_int_msinum;
  logic                                tl_int_status;
  logic                                tl_int_ack;

  modport master (
    output tl_int_req,
    output tl_int_msinum,
    output tl_int_status,
    input  tl_int_ack
  );

  modport slave (
    input  tl_int_req,
    input  tl_int_msinum,
    input  tl_int_status,
    output tl_int_ack
  );

endinterface

// File: rtl/gowin_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module gowin_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          valid
);

  logic [N-1:0] upper;

  // Requests at or above the pointer take precedence over the wrapped ones.
  assign upper = req & ~((N'(1) << ptr) - N'(1));
  assign valid = |req;

  always_comb begin
    grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) grant = PW'(k);
    end
    if (|upper) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (upper[k]) grant = PW'(k);
      end
    end
  end

endmodule

// File: rtl/gowin_msi_arbiter.sv
// Multi-source MSI controller: edge capture, vector folding, round-robin request FSM.
module gowin_msi_arbiter
  import gowin_pcie_pkg::*;
#(
  parameter int C_NUM_SRC     = 12,
  parameter int C_NUM_VEC     = 4,
  parameter int C_ACK_TIMEOUT = 1023,
  parameter int C_HOLDOFF     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [C_NUM_SRC-1:0] src_irq,
  input  logic                 cfg_msi_en,
  input  logic [2:0]           cfg_msi_mmen,
  gowin_msi_arbiter_if.master  irq_bus,
  output logic [C_NUM_VEC-1:0] vec_pending,
  output logic                 timeout_err
);

  localparam int VW = (C_NUM_VEC > 1) ? $clog2(C_NUM_VEC) : 1;
  localparam int TW = (C_ACK_TIMEOUT > 0) ? $clog2(C_ACK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = (C_ACK_TIMEOUT > 0) ? TW'(C_ACK_TIMEOUT - 1) : '0;
  localparam logic [7:0]    HOLD_LAST  = (C_HOLDOFF > 0) ? 8'(C_HOLDOFF - 1) : 8'd0;
  localparam msi_state_t    AFTER_REQ  = (C_HOLDOFF == 0) ? MSI_IDLE : MSI_HOLDOFF;

  msi_state_t           state_reg, state_next;
  logic [C_NUM_SRC-1:0] src_q_reg;
  logic                 armed_reg;
  logic [C_NUM_VEC-1:0] pending_reg, pending_next;
  logic [VW-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [VW-1:0]        grant_reg, grant_next;
  logic                 req_reg, req_next;
  logic [MSINUM_W-1:0]  msinum_reg, msinum_next;
  logic                 status_reg, status_next;
  logic                 tmo_reg, tmo_next;
  logic [TW-1:0]        timer_reg, timer_next;
  logic [7:0]           hold_reg, hold_next;

  logic [C_NUM_SRC-1:0] src_event;
  logic [C_NUM_VEC-1:0] set_vec, clr_vec, reload_vec;
  logic [VW-1:0]        pick_idx;
  logic                 pick_valid;
  int unsigned          granted;
  int unsigned          eff;

  // The first cycle after reset only primes the history, so a level already high is not an edge.
  assign src_event = src_irq & ~src_q_reg & {C_NUM_SRC{armed_reg}};

  assign granted = 32'd1 << cfg_msi_mmen;
  assign eff     = (granted < 32'(C_NUM_VEC)) ? granted : 32'(C_NUM_VEC);

  genvar gi, gj;
  generate
    for (gi = 0; gi < C_NUM_VEC; gi++) begin : g_vec
      logic [C_NUM_SRC-1:0] hit;
      for (gj = 0; gj < C_NUM_SRC; gj++) begin : g_src
        assign hit[gj] = src_event[gj] && (fold_vec(gj, eff) == 32'(gi));
      end
      assign set_vec[gi] = |hit;
    end
  endgenerate

  gowin_rr_pick #(
    .N  (C_NUM_VEC),
    .PW (VW)
  ) u_pick (
    .req   (pending_reg),
    .ptr   (rr_ptr_reg),
    .grant (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    req_next    = req_reg;
    msinum_next = msinum_reg;
    tmo_next    = 1'b0;
    timer_next  = timer_reg;
    hold_next   = hold_reg;
    clr_vec     = '0;
    reload_vec  = '0;

    case (state_reg)
      MSI_IDLE: begin
        if (cfg_msi_en && pick_valid) begin
          state_next  = MSI_REQ;
          req_next    = 1'b1;
          grant_next  = pick_idx;
          msinum_next = MSINUM_W'(fold_vec(32'(pick_idx), eff));
          clr_vec     = (C_NUM_VEC)'(1) << pick_idx;
          rr_ptr_next = (pick_idx == VW'(C_NUM_VEC - 1)) ? '0 : pick_idx + 1'b1;
          timer_next  = '0;
        end
      end

      MSI_REQ: begin
        if (irq_bus.tl_int_ack) begin
          req_next   = 1'b0;
          state_next = AFTER_REQ;
          hold_next  = '0;
        end else if (!cfg_msi_en) begin
          // Disabled mid-flight: hand the vector back without flagging an error.
          req_next   = 1'b0;
          reload_vec = (C_NUM_VEC)'(1) << grant_reg;
          state_next = MSI_IDLE;
        end else if ((C_ACK_TIMEOUT != 0) && (timer_reg == TIMER_LAST)) begin
          req_next   = 1'b0;
          reload_vec = (C_NUM_VEC)'(1) << grant_reg;
          tmo_next   = 1'b1;
          state_next = AFTER_REQ;
          hold_next  = '0;
        end else if (timer_reg != '1) begin
          timer_next = timer_reg + 1'b1;
        end
      end

      MSI_HOLDOFF: begin
        if (hold_reg == HOLD_LAST) state_next = MSI_IDLE;
        else                       hold_next  = hold_reg + 1'b1;
      end

      default: state_next = MSI_IDLE;
    endcase

    // A new event outranks the clear of the bit being granted this cycle.
    pending_next = (pending_reg & ~clr_vec) | set_vec | reload_vec;
    status_next  = (|pending_next) | (state_next == MSI_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= MSI_IDLE;
      src_q_reg   <= '0;
      armed_reg   <= 1'b0;
      pending_reg <= '0;
      rr_ptr_reg  <= '0;
      grant_reg   <= '0;
      req_reg     <= 1'b0;
      msinum_reg  <= '0;
      status_reg  <= 1'b0;
      tmo_reg     <= 1'b0;
      timer_reg   <= '0;
      hold_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      src_q_reg   <= src_irq;
      armed_reg   <= 1'b1;
      pending_reg <= pending_next;
      rr_ptr_reg  <= rr_ptr_next;
      grant_reg   <= grant_next;
      req_reg     <= req_next;
      msinum_reg  <= msinum_next;
      status_reg  <= status_next;
      tmo_reg     <= tmo_next;
      timer_reg   <= timer_next;
      hold_reg    <= hold_next;
    end
  end

  assign irq_bus.tl_int_req    = req_reg;
  assign irq_bus.tl_int_msinum = msinum_reg;
  assign irq_bus.tl_int_status = status_reg;
  assign vec_pending           = pending_reg;
  assign timeout_err           = tmo_reg;

endmodule

// File: tb/tb_gowin_msi_arbiter.sv
// Directed scoreboard bench for gowin_msi_arbiter (12 sources, 4 vectors, timeout 8, hold-off 4).
module tb_gowin_msi_arbiter;

  localparam int NSRC = 12;
  localparam int NVEC = 4;
  localparam int TMO  = 8;
  localparam int HOLD = 4;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [NSRC-1:0] src_irq = '0;
  logic            en   = 1'b0;
  logic [2:0]      mmen = 3'd0;
  logic [NVEC-1:0] vec_pending;
  logic            timeout_err;

  gowin_msi_arbiter_if bus();

  gowin_msi_arbiter #(
    .C_NUM_SRC     (NSRC),
    .C_NUM_VEC     (NVEC),
    .C_ACK_TIMEOUT (TMO),
    .C_HOLDOFF     (HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_irq      (src_irq),
    .cfg_msi_en   (en),
    .cfg_msi_mmen (mmen),
    .irq_bus      (bus),
    .vec_pending  (vec_pending),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  int         rises = 0;
  int         tmo_cnt = 0;
  logic       req_prev = 1'b0;
  logic [4:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge and score any new request.
  task automatic tick();
    logic [4:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.tl_int_req && !req_prev) begin
      rises++;
      rise_cyc = cyc;
      $display("cyc %0d: request msinum=%0d pending=%b", cyc, bus.tl_int_msinum, vec_pending);
      if (exp_q.size() == 0) begin
        chk("unexpected_req_queue", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("msinum", {27'd0, bus.tl_int_msinum}, {27'd0, e});
      end
    end
    if (timeout_err) tmo_cnt++;
    req_prev = bus.tl_int_req;
  endtask

  task automatic wait_req(input string tag, input int budget);
    int r0;
    int n;
    r0 = rises;
    n  = 0;
    while (rises == r0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, rises - r0, 1);
  endtask

  task automatic ack_once();
    bus.tl_int_ack = 1'b1;
    tick();
    bus.tl_int_ack = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_req"},     bus.tl_int_req, 0);
    chk({tag, "_msinum"},  {27'd0, bus.tl_int_msinum}, 0);
    chk({tag, "_status"},  bus.tl_int_status, 0);
    chk({tag, "_pending"}, vec_pending, 0);
    chk({tag, "_tmo"},     timeout_err, 0);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    src_irq        = '0;
    bus.tl_int_ack = 1'b0;
    repeat (2) tick();
    rst_n    = 1'b1;
    req_prev = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int tmo0;
    int starts[3];

    // Reset with a source already high: it must not count as an edge.
    bus.tl_int_ack = 1'b0;
    en      = 1'b1;
    mmen    = 3'd2;
    src_irq = 12'h010;
    repeat (2) tick();
    chk_cleared("reset");
    rst_n = 1'b1;
    repeat (4) tick();
    chk("release_edge_pending", vec_pending, 0);
    chk("release_edge_status", bus.tl_int_status, 0);
    src_irq = '0;
    tick();

    // 1: single event, ack three cycles after the request.
    src_irq[2] = 1'b1;
    exp_q.push_back(5'd2);
    wait_req("t1_req", 10);
    chk("t1_pending_cleared", vec_pending, 0);
    chk("t1_status_high", bus.tl_int_status, 1);
    tick();
    tick();
    chk("t1_req_held", bus.tl_int_req, 1);
    chk("t1_msinum_held", {27'd0, bus.tl_int_msinum}, 2);
    ack_once();
    chk("t1_req_dropped", bus.tl_int_req, 0);
    chk("t1_status_fell", bus.tl_int_status, 0);
    src_irq = '0;
    repeat (8) tick();

    // 2: three simultaneous events from a fresh pointer, immediate acks.
    do_reset();
    src_irq = 12'b1011;
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd1);
    exp_q.push_back(5'd3);
    for (int k = 0; k < 3; k++) begin
      wait_req($sformatf("t2_req%0d", k), 20);
      starts[k] = rise_cyc;
      ack_once();
      chk($sformatf("t2_drop%0d", k), bus.tl_int_req, 0);
    end
    chk("t2_spacing01", starts[1] - starts[0], HOLD + 2);
    chk("t2_spacing12", starts[2] - starts[1], HOLD + 2);
    src_irq = '0;
    repeat (8) tick();
    chk("t2_status_idle", bus.tl_int_status, 0);

    // 3: one granted vector folds sources 5 and 6 into a single request.
    mmen = 3'd0;
    r = rises;
    src_irq[5] = 1'b1;
    src_irq[6] = 1'b1;
    exp_q.push_back(5'd0);
    wait_req("t3_req", 10);
    chk("t3_pending_folded", vec_pending, 0);
    ack_once();
    repeat (15) tick();
    chk("t3_single_req", rises - r, 1);
    src_irq = '0;
    mmen = 3'd2;
    tick();

    // 4: no ack; abort after TMO cycles and retry after hold-off.
    tmo0 = tmo_cnt;
    src_irq[7] = 1'b1;
    exp_q.push_back(5'd3);
    wait_req("t4_req", 10);
    r = rise_cyc;
    repeat (TMO - 1) tick();
    chk("t4_req_held", bus.tl_int_req, 1);
    tick();
    chk("t4_req_dropped", bus.tl_int_req, 0);
    chk("t4_tmo_pulse", timeout_err, 1);
    chk("t4_pending_reset", vec_pending, 4'b1000);
    tick();
    chk("t4_tmo_one_cycle", timeout_err, 0);
    exp_q.push_back(5'd3);
    wait_req("t4_rereq", 20);
    chk("t4_rereq_spacing", rise_cyc - r, TMO + HOLD + 1);
    ack_once();
    chk("t4_tmo_count", tmo_cnt - tmo0, 1);
    src_irq = '0;
    repeat (8) tick();

    // 5: disable mid-request keeps the vector pending, no timeout flagged.
    tmo0 = tmo_cnt;
    src_irq[9] = 1'b1;
    exp_q.push_back(5'd1);
    wait_req("t5_req", 10);
    tick();
    tick();
    en = 1'b0;
    tick();
    chk("t5_req_dropped", bus.tl_int_req, 0);
    chk("t5_pending_kept", vec_pending, 4'b0010);
    chk("t5_status_pending", bus.tl_int_status, 1);
    repeat (5) tick();
    chk("t5_idle_disabled", bus.tl_int_req, 0);
    en = 1'b1;
    exp_q.push_back(5'd1);
    wait_req("t5_rereq", 5);
    ack_once();
    chk("t5_no_tmo", tmo_cnt - tmo0, 0);
    src_irq = '0;
    repeat (8) tick();

    // 6: new edge on vector 1 in its own grant cycle, then reset mid-request.
    src_irq[5] = 1'b1;
    exp_q.push_back(5'd1);
    exp_q.push_back(5'd1);
    tick();
    src_irq[1] = 1'b1;
    tick();
    chk("t6_first_req", bus.tl_int_req, 1);
    chk("t6_pending_kept", vec_pending, 4'b0010);
    ack_once();
    wait_req("t6_second_req", 15);
    tick();
    rst_n = 1'b0;
    #1;
    chk_cleared("t6_async_reset");
    tick();
    req_prev = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
